sram_port_arbiter: RTL and testbench

- Shares one unit_SRAM_8k_8_32 instance between two fabric requesters, A and B.
- Arbitrates the SRAM write port and read port independently; at most one write grant and one read grant per cycle.
- Resolves same-address write/read hazards and routes returned read data to the issuing requester.
- Sits between fabric-side requesters and the SRAM unit's csb/web/reb/addr_w/addr_r/d_fabric_in/d_fabric_out pins.

---
 rtl/sram_port_arbiter_if.sv | 29 ++
 rtl/sram_port_arbiter.sv | 126 ++++++++++++
 tb/tb_sram_port_arbiter.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/sram_port_arbiter_if.sv
// rtl/sram_port_arbiter_if.sv - requester-side op/response bundle for sram_port_arbiter
// Purpose: one fabric requester's view of the shared SRAM.
//   valid/we/addr/wdata : op from requester; held stable until ready
//   ready               : op accepted this cycle (valid && ready transfers)
//   rvalid/rdata        : read data return, rdata meaningful only with rvalid
// Modports: master = requester side, slave = arbiter side.

interface sram_port_arbiter_if #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32
);
   logic              valid;
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic              ready;
   logic              rvalid;
   logic [DATA_W-1:0] rdata;

   modport master (
      output valid, we, addr, wdata,
      input  ready, rvalid, rdata
   );

   modport slave (
      input  valid, we, addr, wdata,
      output ready, rvalid, rdata
   );
endinterface

// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - shares one SRAM write port and read port between requesters A and B
// Purpose: independent round-robin arbitration of the SRAM write and read ports,
//          same-address write/read hazard stall, and routing of read data back
//          to the requester that issued the read.
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset
//   a, b               : requester bundles (sram_port_arbiter_if.slave)
//   sram_csb/web/reb   : active-low chip select / write enable / read enable
//   sram_addr_w/addr_r : write / read address (hold last granted value when idle)
//   sram_d_in          : write data (holds last granted value when idle)
//   sram_d_out         : read data, valid READ_LAT cycles after a read grant

module sram_port_arbiter #(
   parameter int ADDR_W   = 10,
   parameter int DATA_W   = 32,
   parameter int READ_LAT = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   sram_port_arbiter_if.slave a,
   sram_port_arbiter_if.slave b,
   output logic              sram_csb,
   output logic              sram_web,
   output logic              sram_reb,
   output logic [ADDR_W-1:0] sram_addr_w,
   output logic [ADDR_W-1:0] sram_addr_r,
   output logic [DATA_W-1:0] sram_d_in,
   input  logic [DATA_W-1:0] sram_d_out
);

   // Grants are enabled from the first clock edge after reset release, so
   // ready and the SRAM strobes stay inactive for the whole reset period.
   logic              run_en;

   // Tie-break pointers: 0 selects A, 1 selects B.
   logic              wr_ptr;
   logic              rd_ptr;

   logic [ADDR_W-1:0] addr_w_q;
   logic [ADDR_W-1:0] addr_r_q;
   logic [DATA_W-1:0] d_in_q;

   // Response pipe: index 0 is depth 1, index READ_LAT-1 is the output stage.
   logic [READ_LAT-1:0] pipe_v;
   logic [READ_LAT-1:0] pipe_id;

   logic a_wr_req, b_wr_req, a_rd_req, b_rd_req;
   logic wr_gnt_a, wr_gnt_b, wr_gnt;
   logic rd_cand_a, rd_cand_b, rd_cand;
   logic rd_gnt_a, rd_gnt_b, rd_gnt;
   logic hazard;
   logic [ADDR_W-1:0] wr_addr;
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] wr_data;

   assign a_wr_req = run_en & a.valid &  a.we;
   assign b_wr_req = run_en & b.valid &  b.we;
   assign a_rd_req = run_en & a.valid & ~a.we;
   assign b_rd_req = run_en & b.valid & ~b.we;

   assign wr_gnt_a = a_wr_req & (~b_wr_req | ~wr_ptr);
   assign wr_gnt_b = b_wr_req & (~a_wr_req |  wr_ptr);
   assign wr_gnt   = wr_gnt_a | wr_gnt_b;

   assign rd_cand_a = a_rd_req & (~b_rd_req | ~rd_ptr);
   assign rd_cand_b = b_rd_req & (~a_rd_req |  rd_ptr);
   assign rd_cand   = rd_cand_a | rd_cand_b;

   assign wr_addr = wr_gnt_b  ? b.addr  : a.addr;
   assign wr_data = wr_gnt_b  ? b.wdata : a.wdata;
   assign rd_addr = rd_cand_b ? b.addr  : a.addr;

   // A read colliding with the write granted in the same cycle waits a cycle
   // so that it observes the newly written data.
   assign hazard = wr_gnt & rd_cand & (wr_addr == rd_addr);

   assign rd_gnt_a = rd_cand_a & ~hazard;
   assign rd_gnt_b = rd_cand_b & ~hazard;
   assign rd_gnt   = rd_gnt_a | rd_gnt_b;

   assign a.ready = wr_gnt_a | rd_gnt_a;
   assign b.ready = wr_gnt_b | rd_gnt_b;

   assign sram_csb    = ~(wr_gnt | rd_gnt);
   assign sram_web    = ~wr_gnt;
   assign sram_reb    = ~rd_gnt;
   assign sram_addr_w = wr_gnt ? wr_addr : addr_w_q;
   assign sram_addr_r = rd_gnt ? rd_addr : addr_r_q;
   assign sram_d_in   = wr_gnt ? wr_data : d_in_q;

   assign a.rvalid = pipe_v[READ_LAT-1] & ~pipe_id[READ_LAT-1];
   assign b.rvalid = pipe_v[READ_LAT-1] &  pipe_id[READ_LAT-1];
   assign a.rdata  = sram_d_out;
   assign b.rdata  = sram_d_out;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_en   <= 1'b0;
         wr_ptr   <= 1'b0;
         rd_ptr   <= 1'b0;
         addr_w_q <= '0;
         addr_r_q <= '0;
         d_in_q   <= '0;
         pipe_v   <= '0;
         pipe_id  <= '0;
      end else begin
         run_en <= 1'b1;
         if (wr_gnt) begin
            wr_ptr   <= wr_gnt_a;     // point at the requester that lost
            addr_w_q <= wr_addr;
            d_in_q   <= wr_data;
         end
         if (rd_gnt) begin
            rd_ptr   <= rd_gnt_a;
            addr_r_q <= rd_addr;
         end
         pipe_v[0]  <= rd_gnt;
         pipe_id[0] <= rd_gnt_b;
         for (int i = 1; i < READ_LAT; i++) begin
            pipe_v[i]  <= pipe_v[i-1];
            pipe_id[i] <= pipe_id[i-1];
         end
      end
   end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb/tb_sram_port_arbiter.sv - directed vector bench for sram_port_arbiter at READ_LAT 2 and 3

module tb_sram_port_arbiter;
   localparam int AW = 10;
   localparam int DW = 32;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   sram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) ra2 ();
   sram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) rb2 ();
   sram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) ra3 ();
   sram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) rb3 ();

   logic          csb2, web2, reb2, csb3, web3, reb3;
   logic [AW-1:0] aw2, ar2, aw3, ar3;
   logic [DW-1:0] din2, din3, dout2, dout3;

   // Second instance sees identical requests; only its read latency differs.
   assign ra3.valid = ra2.valid;
   assign ra3.we    = ra2.we;
   assign ra3.addr  = ra2.addr;
   assign ra3.wdata = ra2.wdata;
   assign rb3.valid = rb2.valid;
   assign rb3.we    = rb2.we;
   assign rb3.addr  = rb2.addr;
   assign rb3.wdata = rb2.wdata;

   sram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .a(ra2), .b(rb2),
      .sram_csb(csb2), .sram_web(web2), .sram_reb(reb2),
      .sram_addr_w(aw2), .sram_addr_r(ar2), .sram_d_in(din2), .sram_d_out(dout2)
   );

   sram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(3)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .a(ra3), .b(rb3),
      .sram_csb(csb3), .sram_web(web3), .sram_reb(reb3),
      .sram_addr_w(aw3), .sram_addr_r(ar3), .sram_d_in(din3), .sram_d_out(dout3)
   );

   // SRAM model: memory preset to 0x1000_0000|addr, read data taps at 2 and 3 cycles.
   logic [DW-1:0] mem [0:(1<<AW)-1];
   logic [DW-1:0] dq  [1:4];

   always @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < (1 << AW); i++) mem[i] <= 32'h1000_0000 | 32'(i);
         for (int k = 1; k <= 4; k++) dq[k] <= '0;
      end else begin
         if (!csb2 && !web2) mem[aw2] <= din2;
         dq[1] <= (!csb2 && !reb2) ? mem[ar2] : '0;
         for (int k = 2; k <= 4; k++) dq[k] <= dq[k-1];
      end
   end
   assign dout2 = dq[2];
   assign dout3 = dq[3];

   typedef struct {
      logic          av, awe;
      logic [AW-1:0] aad;
      logic [DW-1:0] awd;
      logic          bv, bwe;
      logic [AW-1:0] bad;
      logic [DW-1:0] bwd;
      logic          era, erb, ecsb, eweb, ereb;
      logic [AW-1:0] eaw, ear;
      logic [DW-1:0] edin;
      logic          earv, ebrv;
      logic [DW-1:0] erd;
   } vec_t;

   vec_t tv[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic add(input logic av, awe, input logic [AW-1:0] aad, input logic [DW-1:0] awd,
                      input logic bv, bwe, input logic [AW-1:0] bad, input logic [DW-1:0] bwd,
                      input logic era, erb, ecsb, eweb, ereb,
                      input logic [AW-1:0] eaw, ear, input logic [DW-1:0] edin,
                      input logic earv, ebrv, input logic [DW-1:0] erd);
      vec_t v;
      v.av = av;  v.awe = awe;  v.aad = aad;  v.awd = awd;
      v.bv = bv;  v.bwe = bwe;  v.bad = bad;  v.bwd = bwd;
      v.era = era; v.erb = erb; v.ecsb = ecsb; v.eweb = eweb; v.ereb = ereb;
      v.eaw = eaw; v.ear = ear; v.edin = edin;
      v.earv = earv; v.ebrv = ebrv; v.erd = erd;
      tv.push_back(v);
   endtask

   task automatic drive(input logic av, awe, input logic [AW-1:0] aad, input logic [DW-1:0] awd,
                        input logic bv, bwe, input logic [AW-1:0] bad, input logic [DW-1:0] bwd);
      ra2.valid = av; ra2.we = awe; ra2.addr = aad; ra2.wdata = awd;
      rb2.valid = bv; rb2.we = bwe; rb2.addr = bad; rb2.wdata = bwd;
   endtask

   function automatic logic [63:0] bund(input logic ra, rb, csb, web, reb,
                                        input logic [AW-1:0] aw, ar, input logic [DW-1:0] din);
      return 64'({ra, rb, csb, web, reb, aw, ar, din});
   endfunction

   function automatic logic [63:0] rsp(input logic va, vb, input logic [DW-1:0] d);
      return 64'({va, vb, d});
   endfunction

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   // Compares both instances' request-side outputs and each one's read return.
   task automatic chk_all(input string tag, input logic [63:0] eb,
                          input logic [63:0] er2, input logic [63:0] er3);
      check({tag, " bus2"}, bund(ra2.ready, rb2.ready, csb2, web2, reb2, aw2, ar2, din2), eb);
      check({tag, " bus3"}, bund(ra3.ready, rb3.ready, csb3, web3, reb3, aw3, ar3, din3), eb);
      check({tag, " rsp2"}, rsp(ra2.rvalid, rb2.rvalid,
                                ra2.rvalid ? ra2.rdata : (rb2.rvalid ? rb2.rdata : '0)), er2);
      check({tag, " rsp3"}, rsp(ra3.rvalid, rb3.rvalid,
                                ra3.rvalid ? ra3.rdata : (rb3.rvalid ? rb3.rdata : '0)), er3);
   endtask

   task automatic step(input logic av, awe, input logic [AW-1:0] aad, input logic [DW-1:0] awd,
                       input logic bv, bwe, input logic [AW-1:0] bad, input logic [DW-1:0] bwd);
      @(posedge clk);
      #1;
      drive(av, awe, aad, awd, bv, bwe, bad, bwd);
      @(negedge clk);
   endtask

   logic [63:0] rst_bus;
   logic [63:0] none;
   logic [63:0] prev;

   initial begin
      rst_bus = bund(0, 0, 1, 1, 1, '0, '0, '0);
      none    = rsp(0, 0, '0);

      // av awe aad awd | bv bwe bad bwd | ra rb csb web reb | aw ar din | arv brv rd
      add(0,0, 0,0,             0,0, 0,0,      0,0,1,1,1,  0, 0,32'h0,        0,0,32'h0);
      add(1,1, 5,32'hDEADBEEF,  0,0, 0,0,      1,0,0,0,1,  5, 0,32'hDEADBEEF, 0,0,32'h0);
      add(1,0, 5,0,             0,0, 0,0,      1,0,0,1,0,  5, 5,32'hDEADBEEF, 0,0,32'h0);
      add(1,1, 7,32'h11,        1,0, 7,0,      1,0,0,0,1,  7, 5,32'h11,       0,0,32'h0);
      add(0,0, 0,0,             1,0, 7,0,      0,1,0,1,0,  7, 7,32'h11,       1,0,32'hDEADBEEF);
      add(1,0, 3,0,             1,1, 9,32'h99, 1,1,0,0,0,  9, 3,32'h99,       0,0,32'h0);
      add(1,1, 0,32'hA0,        1,1,16,32'hB0, 1,0,0,0,1,  0, 3,32'hA0,       0,1,32'h11);
      add(1,1, 1,32'hA1,        1,1,16,32'hB0, 0,1,0,0,1, 16, 3,32'hB0,       1,0,32'h1000_0003);
      add(1,1, 1,32'hA1,        1,1,17,32'hB1, 1,0,0,0,1,  1, 3,32'hA1,       0,0,32'h0);
      add(1,1, 2,32'hA2,        1,1,17,32'hB1, 0,1,0,0,1, 17, 3,32'hB1,       0,0,32'h0);
      add(1,1, 2,32'hA2,        1,1,18,32'hB2, 1,0,0,0,1,  2, 3,32'hA2,       0,0,32'h0);
      add(1,1, 3,32'hA3,        1,1,18,32'hB2, 0,1,0,0,1, 18, 3,32'hB2,       0,0,32'h0);
      add(1,1, 3,32'hA3,        1,1,19,32'hB3, 1,0,0,0,1,  3, 3,32'hA3,       0,0,32'h0);
      add(0,0, 0,0,             1,1,19,32'hB3, 0,1,0,0,1, 19, 3,32'hB3,       0,0,32'h0);
      add(1,0, 1,0,             1,0, 2,0,      0,1,0,1,0, 19, 2,32'hB3,       0,0,32'h0);
      add(1,0, 1,0,             1,0,16,0,      1,0,0,1,0, 19, 1,32'hB3,       0,0,32'h0);
      add(0,0, 0,0,             1,0,16,0,      0,1,0,1,0, 19,16,32'hB3,       0,1,32'hA2);
      add(1,0, 0,0,             0,0, 0,0,      1,0,0,1,0, 19, 0,32'hB3,       1,0,32'hA1);
      add(0,0, 0,0,             0,0, 0,0,      0,0,1,1,1, 19, 0,32'hB3,       0,1,32'hB0);
      add(0,0, 0,0,             0,0, 0,0,      0,0,1,1,1, 19, 0,32'hB3,       1,0,32'hA0);
      add(1,0, 3,0,             1,0,19,0,      0,1,0,1,0, 19,19,32'hB3,       0,0,32'h0);
      add(1,0, 3,0,             0,0, 0,0,      1,0,0,1,0, 19, 3,32'hB3,       0,0,32'h0);
      add(0,0, 0,0,             1,0, 9,0,      0,1,0,1,0, 19, 9,32'hB3,       0,1,32'hB3);
      add(0,0, 0,0,             0,0, 0,0,      0,0,1,1,1, 19, 9,32'hB3,       1,0,32'hA3);
      add(0,0, 0,0,             0,0, 0,0,      0,0,1,1,1, 19, 9,32'hB3,       0,1,32'h99);
      add(0,0, 0,0,             0,0, 0,0,      0,0,1,1,1, 19, 9,32'hB3,       0,0,32'h0);

      // Reset with both requesters pushing ops: nothing may be granted.
      rst_n = 1'b0;
      drive(1, 1, 5, 32'h55, 1, 0, 6, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_all("in_reset", rst_bus, none, none);
      @(posedge clk);
      #1;
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      rst_n = 1'b1;

      // Table: the latency-3 instance returns one cycle after the latency-2 one.
      for (int i = 0; i < tv.size(); i++) begin
         @(posedge clk);
         #1;
         drive(tv[i].av, tv[i].awe, tv[i].aad, tv[i].awd, tv[i].bv, tv[i].bwe, tv[i].bad, tv[i].bwd);
         @(negedge clk);
         prev = (i > 0) ? rsp(tv[i-1].earv, tv[i-1].ebrv, tv[i-1].erd) : none;
         chk_all($sformatf("vec%0d", i),
                 bund(tv[i].era, tv[i].erb, tv[i].ecsb, tv[i].eweb, tv[i].ereb,
                      tv[i].eaw, tv[i].ear, tv[i].edin),
                 rsp(tv[i].earv, tv[i].ebrv, tv[i].erd), prev);
      end

      // Mid-stream reset: A write + B read, then A read, then reset right after.
      // Leaves wr_ptr and rd_ptr both pointing at B before the reset.
      step(1, 1, 60, 32'h60, 1, 0, 2, 0);
      chk_all("pre_rst0", bund(1, 1, 0, 0, 0, 60, 2, 32'h60), none, none);
      step(1, 0, 1, 0, 0, 0, 0, 0);
      chk_all("pre_rst1", bund(1, 0, 0, 1, 0, 60, 1, 32'h60), none, none);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      drive(1, 1, 7, 32'h77, 1, 1, 8, 32'h88);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk_all($sformatf("mid_rst%0d", c), rst_bus, none, none);
         @(posedge clk);
      end
      #1;
      rst_n = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk_all($sformatf("post_idle%0d", c), rst_bus, none, none);
         @(posedge clk);
      end

      // After reset both tie-breaks favour A again.
      step(1, 1, 40, 32'h40, 1, 1, 41, 32'h41);
      chk_all("post_w0", bund(1, 0, 0, 0, 1, 40, 0, 32'h40), none, none);
      step(0, 0, 0, 0, 1, 1, 41, 32'h41);
      chk_all("post_w1", bund(0, 1, 0, 0, 1, 41, 0, 32'h41), none, none);
      step(1, 0, 40, 0, 1, 0, 41, 0);
      chk_all("post_r0", bund(1, 0, 0, 1, 0, 41, 40, 32'h41), none, none);
      step(0, 0, 0, 0, 1, 0, 41, 0);
      chk_all("post_r1", bund(0, 1, 0, 1, 0, 41, 41, 32'h41), none, none);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      chk_all("post_rv0", bund(0, 0, 1, 1, 1, 41, 41, 32'h41), rsp(1, 0, 32'h40), none);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      chk_all("post_rv1", bund(0, 0, 1, 1, 1, 41, 41, 32'h41), rsp(0, 1, 32'h41), rsp(1, 0, 32'h40));
      step(0, 0, 0, 0, 0, 0, 0, 0);
      chk_all("post_rv2", bund(0, 0, 1, 1, 1, 41, 41, 32'h41), none, rsp(0, 1, 32'h41));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
